// File: rtl/bcd_counter_ndigit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_ndigit
// Brief    : Registered N-digit BCD up/down counter with synchronous load,
//            load-time digit clamping and one-cycle carry/borrow/error pulses.
//            Optional macro BCD_COUNTER_SAT_EN adds an i_sat input that makes
//            counting saturate at the limits instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_ndigit #(
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_value,
`ifdef BCD_COUNTER_SAT_EN
    input  logic                  i_sat,
`endif
    output logic [4*DIGITS-1:0]   o_value,
    output logic                  o_carry,
    output logic                  o_borrow,
    output logic                  o_load_err,
    output logic                  o_zero,
    output logic                  o_max
);

    localparam int c_width = 4 * DIGITS;

    logic [c_width-1:0] r_value_q;
    logic               r_carry_q;
    logic               r_borrow_q;
    logic               r_load_err_q;

    logic [c_width-1:0] w_value_d;
    logic               w_carry_d;
    logic               w_borrow_d;
    logic               w_load_err_d;
    logic               w_ripple;
    logic [3:0]         w_digit;
    logic               w_sat;
    logic               w_max;

`ifdef BCD_COUNTER_SAT_EN
    assign w_sat = i_sat;
`else
    assign w_sat = 1'b0;
`endif

    // Next-state: load with clamp, else single-step ripple count, else hold.
    always_comb begin
        w_value_d    = r_value_q;
        w_carry_d    = 1'b0;
        w_borrow_d   = 1'b0;
        w_load_err_d = 1'b0;
        w_ripple     = 1'b0;
        w_digit      = 4'd0;
        if (i_load) begin
            for (int k = 0; k < DIGITS; k++) begin
                w_digit = i_load_value[4*k +: 4];
                if (w_digit > 4'd9) begin
                    w_value_d[4*k +: 4] = 4'd9;
                    w_load_err_d        = 1'b1;
                end else begin
                    w_value_d[4*k +: 4] = w_digit;
                end
            end
        end else if (i_en) begin
            // w_ripple carries the +1/-1 up the digit chain; it starts set
            // because digit 0 always takes the step.
            w_ripple = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                w_digit = r_value_q[4*k +: 4];
                if (w_ripple) begin
                    if (i_up) begin
                        if (w_digit == 4'd9) begin
                            w_value_d[4*k +: 4] = 4'd0;
                        end else begin
                            w_value_d[4*k +: 4] = w_digit + 4'd1;
                            w_ripple            = 1'b0;
                        end
                    end else begin
                        if (w_digit == 4'd0) begin
                            w_value_d[4*k +: 4] = 4'd9;
                        end else begin
                            w_value_d[4*k +: 4] = w_digit - 4'd1;
                            w_ripple            = 1'b0;
                        end
                    end
                end
            end
            // A ripple out of the top digit means the count wrapped.
            if (w_ripple) begin
                w_carry_d  = i_up;
                w_borrow_d = ~i_up;
                if (w_sat) begin
                    w_value_d = r_value_q;
                end
            end
        end
    end

    // State and pulse registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_value_q    <= '0;
            r_carry_q    <= 1'b0;
            r_borrow_q   <= 1'b0;
            r_load_err_q <= 1'b0;
        end else begin
            r_value_q    <= w_value_d;
            r_carry_q    <= w_carry_d;
            r_borrow_q   <= w_borrow_d;
            r_load_err_q <= w_load_err_d;
        end
    end

    // All-nines detect over the registered value.
    always_comb begin
        w_max = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_value_q[4*k +: 4] != 4'd9) begin
                w_max = 1'b0;
            end
        end
    end

    assign o_value    = r_value_q;
    assign o_carry    = r_carry_q;
    assign o_borrow   = r_borrow_q;
    assign o_load_err = r_load_err_q;
    assign o_zero     = (r_value_q == '0);
    assign o_max      = w_max;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_ndigit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_ndigit
// Brief    : Directed self-checking bench for bcd_counter_ndigit (DIGITS=3).
//            Vectors pack {load,en,up, load_value, exp_value, exp_flags}
//            with exp_flags = {carry,borrow,load_err,zero,max}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_ndigit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_en;
    logic        i_up;
    logic        i_load;
    logic [11:0] i_load_value;
`ifdef BCD_COUNTER_SAT_EN
    logic        i_sat;
`endif
    logic [11:0] o_value;
    logic        o_carry;
    logic        o_borrow;
    logic        o_load_err;
    logic        o_zero;
    logic        o_max;
    logic [16:0] w_obs;

    int checks = 0;
    int errors = 0;

    assign w_obs = {o_value, o_carry, o_borrow, o_load_err, o_zero, o_max};

    always #5 i_clk = ~i_clk;

    bcd_counter_ndigit #(.DIGITS(3)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_up         (i_up),
        .i_load       (i_load),
        .i_load_value (i_load_value),
`ifdef BCD_COUNTER_SAT_EN
        .i_sat        (i_sat),
`endif
        .o_value      (o_value),
        .o_carry      (o_carry),
        .o_borrow     (o_borrow),
        .o_load_err   (o_load_err),
        .o_zero       (o_zero),
        .o_max        (o_max)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_en = 1'b1; i_up = 1'b1; i_load = 1'b1; i_load_value = 12'h555;
        tick();
        checks++;
        if (w_obs !== {12'h000, 5'b00010}) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", w_obs, {12'h000, 5'b00010});
        end
        i_rst_n = 1'b1; i_load_value = 12'h123;
        tick();
        i_load = 1'b0;
        tick();
        checks++;
        if (w_obs !== {12'h124, 5'b00000}) begin
            errors++;
            $display("FAIL reset_precount got %h exp %h", w_obs, {12'h124, 5'b00000});
        end
        i_rst_n = 1'b0;
        tick();
        checks++;
        if (w_obs !== {12'h000, 5'b00010}) begin
            errors++;
            $display("FAIL reset_midcount got %h exp %h", w_obs, {12'h000, 5'b00010});
        end
        i_rst_n = 1'b1; i_en = 1'b0;
    endtask

    task automatic test_up_ripple();
        logic [31:0] v [8];
        v[0] = {3'b100, 12'h099, 12'h099, 5'b00000};
        v[1] = {3'b011, 12'h000, 12'h100, 5'b00000};
        v[2] = {3'b100, 12'h998, 12'h998, 5'b00000};
        v[3] = {3'b011, 12'h000, 12'h999, 5'b00001};
        v[4] = {3'b011, 12'h000, 12'h000, 5'b10010};
        v[5] = {3'b000, 12'h000, 12'h000, 5'b00010};
        v[6] = {3'b100, 12'h089, 12'h089, 5'b00000};
        v[7] = {3'b011, 12'h000, 12'h090, 5'b00000};
        for (int k = 0; k < 8; k++) begin
            {i_load, i_en, i_up} = v[k][31:29];
            i_load_value = v[k][28:17];
            tick();
            checks++;
            if (w_obs !== v[k][16:0]) begin
                errors++;
                $display("FAIL up_ripple[%0d] got %h exp %h", k, w_obs, v[k][16:0]);
            end
        end
    endtask

    task automatic test_down_ripple();
        logic [31:0] v [6];
        v[0] = {3'b100, 12'h100, 12'h100, 5'b00000};
        v[1] = {3'b010, 12'h000, 12'h099, 5'b00000};
        v[2] = {3'b100, 12'h000, 12'h000, 5'b00010};
        v[3] = {3'b010, 12'h000, 12'h999, 5'b01001};
        v[4] = {3'b000, 12'h000, 12'h999, 5'b00001};
        v[5] = {3'b010, 12'h000, 12'h998, 5'b00000};
        for (int k = 0; k < 6; k++) begin
            {i_load, i_en, i_up} = v[k][31:29];
            i_load_value = v[k][28:17];
            tick();
            checks++;
            if (w_obs !== v[k][16:0]) begin
                errors++;
                $display("FAIL down_ripple[%0d] got %h exp %h", k, w_obs, v[k][16:0]);
            end
        end
    endtask

    task automatic test_load_clamp();
        logic [31:0] v [5];
        v[0] = {3'b111, 12'h3A7, 12'h397, 5'b00100};
        v[1] = {3'b000, 12'h000, 12'h397, 5'b00000};
        v[2] = {3'b110, 12'hFFF, 12'h999, 5'b00101};
        v[3] = {3'b100, 12'h0B0, 12'h090, 5'b00100};
        v[4] = {3'b110, 12'h000, 12'h000, 5'b00010};
        for (int k = 0; k < 5; k++) begin
            {i_load, i_en, i_up} = v[k][31:29];
            i_load_value = v[k][28:17];
            tick();
            checks++;
            if (w_obs !== v[k][16:0]) begin
                errors++;
                $display("FAIL load_clamp[%0d] got %h exp %h", k, w_obs, v[k][16:0]);
            end
        end
    endtask

    task automatic test_direction_toggle();
        logic [31:0] v [7];
        v[0] = {3'b100, 12'h500, 12'h500, 5'b00000};
        v[1] = {3'b011, 12'h000, 12'h501, 5'b00000};
        v[2] = {3'b010, 12'h000, 12'h500, 5'b00000};
        v[3] = {3'b011, 12'h000, 12'h501, 5'b00000};
        v[4] = {3'b010, 12'h000, 12'h500, 5'b00000};
        v[5] = {3'b011, 12'h000, 12'h501, 5'b00000};
        v[6] = {3'b010, 12'h000, 12'h500, 5'b00000};
        for (int k = 0; k < 7; k++) begin
            {i_load, i_en, i_up} = v[k][31:29];
            i_load_value = v[k][28:17];
            tick();
            checks++;
            if (w_obs !== v[k][16:0]) begin
                errors++;
                $display("FAIL dir_toggle[%0d] got %h exp %h", k, w_obs, v[k][16:0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] v [3];
        v[0] = {3'b100, 12'h042, 12'h042, 5'b00000};
        v[1] = {3'b001, 12'h777, 12'h042, 5'b00000};
        v[2] = {3'b000, 12'h777, 12'h042, 5'b00000};
        for (int k = 0; k < 3; k++) begin
            {i_load, i_en, i_up} = v[k][31:29];
            i_load_value = v[k][28:17];
            tick();
            checks++;
            if (w_obs !== v[k][16:0]) begin
                errors++;
                $display("FAIL hold[%0d] got %h exp %h", k, w_obs, v[k][16:0]);
            end
        end
    endtask

`ifdef BCD_COUNTER_SAT_EN
    task automatic test_saturate();
        logic [31:0] v [8];
        v[0] = {3'b100, 12'h998, 12'h998, 5'b00000};
        v[1] = {3'b011, 12'h000, 12'h999, 5'b00001};
        v[2] = {3'b011, 12'h000, 12'h999, 5'b10001};
        v[3] = {3'b011, 12'h000, 12'h999, 5'b10001};
        v[4] = {3'b100, 12'h001, 12'h001, 5'b00000};
        v[5] = {3'b010, 12'h000, 12'h000, 5'b00010};
        v[6] = {3'b010, 12'h000, 12'h000, 5'b01010};
        v[7] = {3'b010, 12'h000, 12'h999, 5'b01001};
        i_sat = 1'b1;
        for (int k = 0; k < 8; k++) begin
            {i_load, i_en, i_up} = v[k][31:29];
            i_load_value = v[k][28:17];
            if (k == 7) i_sat = 1'b0;
            tick();
            checks++;
            if (w_obs !== v[k][16:0]) begin
                errors++;
                $display("FAIL saturate[%0d] got %h exp %h", k, w_obs, v[k][16:0]);
            end
        end
        i_sat = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef BCD_COUNTER_SAT_EN
        i_sat = 1'b0;
`endif
        test_reset();
        test_up_ripple();
        test_down_ripple();
        test_load_clamp();
        test_direction_toggle();
        test_hold();
`ifdef BCD_COUNTER_SAT_EN
        test_saturate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_counter_ndigit.md
Name: bcd_counter_ndigit

Overview:
- Parametrised, registered N-digit BCD up/down counter with synchronous load.
- Successor to the combinational 3-digit BCD incrementor chain. Adds digit-count parameter, state, decrement, load with digit validation, and wrap flags.
- Used for display counters, event tallies and timer digits feeding 7-segment drivers.

Parameters:
- DIGITS, 3, number of BCD digits (≥1); value width = 4*DIGITS.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  synchronous active-low reset, sampled on i_clk rising edge.
- i_en  input  1  count enable; one step per cycle while high.
- i_up  input  1  direction: 1 = increment, 0 = decrement.
- i_load  input  1  synchronous load strobe.
- i_load_value  input  4*DIGITS  BCD value to load, digit 0 in [3:0].
- o_value  output  4*DIGITS  current BCD count, registered.
- o_carry  output  1  one-cycle pulse: up-count wrapped from all-9s to 0.
- o_borrow  output  1  one-cycle pulse: down-count wrapped from 0 to all-9s.
- o_load_err  output  1  one-cycle pulse: last load contained a digit >9.
- o_zero  output  1  o_value == 0 (combinational from register).
- o_max  output  1  o_value == all digits 9 (combinational from register).

Behaviour:
- Clocking/reset: single clock i_clk. Reset is synchronous, active-low on i_rst_n.
- Reset (i_rst_n=0 at edge): o_value=0, o_carry=0, o_borrow=0, o_load_err=0; hence o_zero=1, o_max=0. Reset overrides load and enable. Reset mid-count discards the in-progress value; no pulse is generated.
- Priority per edge: reset > load > count > hold.
- Load (i_load=1):
  - o_value <= i_load_value, with any digit >9 clamped to 9.
  - o_load_err=1 for that cycle if any digit was clamped.
  - i_en is ignored that cycle; o_carry/o_borrow=0.
- Count (i_en=1, i_load=0):
  - Up: digit 0 +1. A digit at 9 becomes 0 and propagates carry to the next digit. Ripple across all DIGITS within the same cycle.
  - Down: digit 0 −1. A digit at 0 becomes 9 and propagates borrow.
  - Latency: new value visible on o_value the cycle after the sampling edge (registered, 1-cycle).
- Wrap flags:
  - Up from all-9s → o_value=0 and o_carry=1 for exactly one cycle, aligned with the wrapped value.
  - Down from 0 → o_value=all-9s and o_borrow=1 for one cycle.
  - o_carry and o_borrow are never high together.
- Hold (i_en=0, i_load=0): o_value unchanged; o_carry=o_borrow=o_load_err=0.
- Pulse outputs are registered and deassert on the following edge unless re-triggered. Back-to-back wraps (e.g. DIGITS=1 counting up continuously) produce a pulse every 10th cycle.
- Internal digits are always valid BCD (0–9); no binary-to-BCD conversion is performed.
- i_up may change every cycle; only its value at the sampling edge matters.

Optional Feature:
- Macro: BCD_COUNTER_SAT_EN.
- Defined:
  - Adds input port i_sat (1 bit).
  - With i_sat=1, counting saturates: up at all-9s holds all-9s, down at 0 holds 0, and the count does not wrap.
  - o_carry/o_borrow still pulse (one cycle) on each attempted step past the limit, so overflow stays observable.
  - With i_sat=0, behaviour is identical to wrap mode.
- Undefined:
  - No i_sat port; always wraps as described above.

Test Plan:
- Reset: DIGITS=3, drive i_rst_n=0 one edge while i_en=1, i_load=1, i_load_value=12'h555 → o_value=12'h000, all pulses 0, o_zero=1.
- Up ripple: load 12'h099, then i_en=1,i_up=1 for 1 cycle → o_value=12'h100, o_carry=0; load 12'h998, count 2 cycles → 12'h999 (o_max=1) then 12'h000 with o_carry=1 for exactly one cycle.
- Down ripple/wrap: load 12'h100, i_up=0, count 1 → 12'h099; load 12'h000, count 1 → 12'h999 with o_borrow=1 one cycle.
- Load priority and clamp: i_load=1, i_en=1, i_load_value=12'h3A7 → o_value=12'h397, o_load_err=1 one cycle, no count step applied.
- Direction toggle every cycle from 12'h500 with i_en=1 for 6 cycles → sequence 501,500,501,500,501,500; no pulses.
- BCD_COUNTER_SAT_EN defined, i_sat=1: from 12'h998 up 3 cycles → 999, 999, 999 with o_carry pulsing on cycles 2 and 3; from 12'h001 down 2 cycles → 000, 000 with o_borrow on cycle 2.
